// File: rtl/tft_rect_fillmod_if.sv
// Request and call-bus signals of the rectangle-fill sequencer.
// master: the fill engine; slave: the requester plus the TFT function module.
interface tft_rect_fillmod_if;
   logic        start;
   logic [7:0]  x;
   logic [8:0]  y;
   logic [7:0]  w;
   logic [8:0]  h;
   logic [15:0] color;
   logic        busy;
   logic        done;
   logic        err;
   logic [2:0]  call;
   logic        call_done;
   logic [7:0]  addr;
   logic [15:0] data;

   modport master (
      input  start, x, y, w, h, color, call_done,
      output busy, done, err, call, addr, data
   );

   modport slave (
      output start, x, y, w, h, color, call_done,
      input  busy, done, err, call, addr, data
   );
endinterface

// File: rtl/tft_rect_fillmod.sv
// Rectangle-fill sequencer: programs the GRAM window and cursor, then streams w*h pixels.
// Optional TFT_RECT_RESTORE_WINDOW_EN restores the full-screen window after the fill.
//
// state   | meaning
// IDLE    | waiting for start
// CHECK   | bounds check, latch pixel count
// HWIN    | write 0x44 horizontal window
// VSA     | write 0x45 vertical start
// VEA     | write 0x46 vertical end
// CURX    | write 0x4E cursor x
// CURY    | write 0x4F cursor y
// GRAM    | command 0x22
// PIX     | data write of fill colour, repeated w*h times
// RHWIN   | restore 0x44 full width
// RVSA    | restore 0x45 top
// RVEA    | restore 0x46 bottom
// DONE    | completion pulse
module tft_rect_fillmod #(
   parameter int H_RES = 240,
   parameter int V_RES = 320
) (
   input logic CLOCK,
   input logic RESET,
   tft_rect_fillmod_if.master bus
);

   localparam logic [9:0]  H_LIM      = 10'(H_RES);
   localparam logic [9:0]  V_LIM      = 10'(V_RES);
   localparam logic [15:0] WIN_H_FULL = {8'(H_RES - 1), 8'd0};
   localparam logic [15:0] WIN_V_END  = 16'(V_RES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_HWIN, S_VSA, S_VEA, S_CURX, S_CURY,
      S_GRAM, S_PIX, S_RHWIN, S_RVSA, S_RVEA, S_DONE
   } state_t;

   state_t      state, state_nx, call_next;
   logic        active, active_nx;
   logic [7:0]  x_q, w_q;
   logic [8:0]  y_q, h_q;
   logic [15:0] color_q;
   logic [16:0] last_q, pix_q;
   logic        err_q;

   logic [7:0]  xe;
   logic [8:0]  ye;
   logic [9:0]  x_sum, y_sum;
   logic [16:0] area;
   logic        reject;
   logic [2:0]  sel_call;
   logic [7:0]  sel_addr;
   logic [15:0] sel_data;

   assign xe     = x_q + w_q - 8'd1;
   assign ye     = y_q + h_q - 9'd1;
   assign x_sum  = {2'b00, x_q} + {2'b00, w_q};
   assign y_sum  = {1'b0, y_q} + {1'b0, h_q};
   assign reject = (w_q == 8'd0) || (h_q == 9'd0) || (x_sum > H_LIM) || (y_sum > V_LIM);
   assign area   = {9'd0, w_q} * {8'd0, h_q};

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state  <= S_IDLE;
         active <= 1'b0;
      end else begin
         state  <= state_nx;
         active <= active_nx;
      end
   end

   // Every call state spends one cycle with active low, which forms the gap between calls.
   always_comb begin
      state_nx  = state;
      active_nx = active;
      sel_call  = 3'b000;
      sel_addr  = 8'h00;
      sel_data  = 16'h0000;
      call_next = S_DONE;
      case (state)
         S_HWIN:  begin sel_call = 3'b100; sel_addr = 8'h44; sel_data = {xe, x_q};       call_next = S_VSA;  end
         S_VSA:   begin sel_call = 3'b100; sel_addr = 8'h45; sel_data = {7'd0, y_q};     call_next = S_VEA;  end
         S_VEA:   begin sel_call = 3'b100; sel_addr = 8'h46; sel_data = {7'd0, ye};      call_next = S_CURX; end
         S_CURX:  begin sel_call = 3'b100; sel_addr = 8'h4E; sel_data = {8'd0, x_q};     call_next = S_CURY; end
         S_CURY:  begin sel_call = 3'b100; sel_addr = 8'h4F; sel_data = {7'd0, y_q};     call_next = S_GRAM; end
         S_GRAM:  begin sel_call = 3'b010; sel_addr = 8'h22;                             call_next = S_PIX;  end
         S_PIX: begin
            sel_call = 3'b001;
            sel_data = color_q;
            if (pix_q == last_q) begin
`ifdef TFT_RECT_RESTORE_WINDOW_EN
               call_next = S_RHWIN;
`else
               call_next = S_DONE;
`endif
            end else begin
               call_next = S_PIX;
            end
         end
         S_RHWIN: begin sel_call = 3'b100; sel_addr = 8'h44; sel_data = WIN_H_FULL; call_next = S_RVSA; end
         S_RVSA:  begin sel_call = 3'b100; sel_addr = 8'h45; sel_data = 16'h0000;   call_next = S_RVEA; end
         S_RVEA:  begin sel_call = 3'b100; sel_addr = 8'h46; sel_data = WIN_V_END;  call_next = S_DONE; end
         default: ;
      endcase

      case (state)
         S_IDLE:  if (bus.start) state_nx = S_CHECK;
         S_CHECK: state_nx = reject ? S_DONE : S_HWIN;
         S_DONE:  state_nx = S_IDLE;
         default: begin
            if (!active) begin
               active_nx = 1'b1;
            end else if (bus.call_done) begin
               active_nx = 1'b0;
               state_nx  = call_next;
            end
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
         last_q  <= '0;
         pix_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state == S_IDLE && bus.start) begin
            x_q     <= bus.x;
            y_q     <= bus.y;
            w_q     <= bus.w;
            h_q     <= bus.h;
            color_q <= bus.color;
         end
         if (state == S_CHECK) begin
            err_q  <= reject;
            last_q <= area - 17'd1;
            pix_q  <= '0;
         end
         if (state == S_PIX && active && bus.call_done)
            pix_q <= pix_q + 17'd1;
      end
   end

   assign bus.call = active ? sel_call : 3'b000;
   assign bus.addr = active ? sel_addr : 8'h00;
   assign bus.data = active ? sel_data : 16'h0000;
   assign bus.busy = (state != S_IDLE) && (state != S_DONE);
   assign bus.done = (state == S_DONE);
   assign bus.err  = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_tft_rect_fillmod.sv
// Directed bench for tft_rect_fillmod: call sequences, rejects, random acknowledge delay, abort.
// Restore-window expectations follow TFT_RECT_RESTORE_WINDOW_EN.
module tb_tft_rect_fillmod;

`ifdef TFT_RECT_RESTORE_WINDOW_EN
   localparam int N_RESTORE = 3;
`else
   localparam int N_RESTORE = 0;
`endif

   logic CLOCK = 1'b0;
   logic RESET = 1'b0;
   always #5 CLOCK = ~CLOCK;

   tft_rect_fillmod_if bus ();

   tft_rect_fillmod dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] q[$];
   logic [31:0] exp_hdr [5];
   logic [31:0] rst_exp [3];
   int          pix_seen = 0;
   int          stab_err = 0;
   int          gap_err  = 0;
   int          hot_err  = 0;
   int          resp_max = 0;
   bit          noise_en = 1'b0;
   bit          in_call  = 1'b0;
   int          wait_cnt = 0;
   logic [31:0] cur;
   logic [2:0]  prev_call = 3'b000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Function-module model: records each call, acks after a random delay, checks stability and gaps.
   initial begin
      bus.call_done = 1'b0;
      forever begin
         @(negedge CLOCK);
         bus.call_done = 1'b0;
         if (!RESET) begin
            in_call   = 1'b0;
            prev_call = 3'b000;
         end else begin
            if (bus.call != 3'b000) begin
               if (!$onehot(bus.call)) hot_err++;
               if (!in_call) begin
                  if (prev_call != 3'b000) gap_err++;
                  in_call = 1'b1;
                  cur = {5'd0, bus.call, bus.addr, bus.data};
                  q.push_back(cur);
                  if (bus.call == 3'b001) pix_seen++;
                  wait_cnt = (resp_max == 0) ? 0 : int'($urandom_range(resp_max, 0));
               end else if ({5'd0, bus.call, bus.addr, bus.data} != cur) begin
                  stab_err++;
               end
               if (wait_cnt == 0) begin
                  bus.call_done = 1'b1;
                  in_call = 1'b0;
               end else begin
                  wait_cnt--;
               end
            end else begin
               if (in_call) stab_err++;
               in_call = 1'b0;
               if (noise_en && $urandom_range(1, 0) == 1) bus.call_done = 1'b1;
            end
            prev_call = bus.call;
         end
      end
   end

   task automatic set_hdr(input logic [31:0] a, b, c, d, e);
      exp_hdr[0] = a; exp_hdr[1] = b; exp_hdr[2] = c; exp_hdr[3] = d; exp_hdr[4] = e;
   endtask

   task automatic run_fill(input logic [7:0] x, input logic [8:0] y, input logic [7:0] w,
                           input logic [8:0] h, input logic [15:0] color, input int max_d,
                           input bit noise, output int cyc, output logic err_seen);
      int busy_bad;
      busy_bad = 0;
      err_seen = 1'b0;
      @(negedge CLOCK);
      q.delete();
      pix_seen  = 0;
      resp_max  = max_d;
      noise_en  = noise;
      bus.x     = x;
      bus.y     = y;
      bus.w     = w;
      bus.h     = h;
      bus.color = color;
      bus.start = 1'b1;
      @(negedge CLOCK);
      bus.start = 1'b0;
      bus.x     = 8'($urandom);
      bus.y     = 9'($urandom);
      bus.w     = 8'($urandom);
      bus.h     = 9'($urandom);
      bus.color = 16'($urandom);
      cyc = 1;
      while (!bus.done && cyc < 30000) begin
         if (!bus.busy) busy_bad++;
         @(negedge CLOCK);
         cyc++;
      end
      check("done_seen", {31'd0, bus.done}, 32'd1);
      if (bus.done) begin
         err_seen = bus.err;
         check("busy_at_done", {31'd0, bus.busy}, 32'd0);
         check("busy_during", 32'(busy_bad), 32'd0);
         @(negedge CLOCK);
         check("done_single", {31'd0, bus.done}, 32'd0);
      end
      noise_en = 1'b0;
   endtask

   task automatic check_seq(input string tag, input int npix, input logic [15:0] color);
      int n_exp;
      int bad;
      n_exp = 6 + npix + N_RESTORE;
      bad   = 0;
      check({tag, ":calls"}, 32'(q.size()), 32'(n_exp));
      if (q.size() == n_exp) begin
         for (int i = 0; i < 5; i++)
            check($sformatf("%s:hdr%0d", tag, i), q[i], exp_hdr[i]);
         check({tag, ":gram"}, {16'd0, q[5][31:16]}, 32'h0000_0222);
         for (int i = 6; i < 6 + npix; i++)
            if (q[i][26:24] !== 3'b001 || q[i][15:0] !== color) bad++;
         check({tag, ":pix"}, 32'(bad), 32'd0);
         for (int i = 0; i < N_RESTORE; i++)
            check($sformatf("%s:restore%0d", tag, i), q[6 + npix + i], rst_exp[i]);
      end
      check({tag, ":stable"}, 32'(stab_err), 32'd0);
      check({tag, ":gap"}, 32'(gap_err), 32'd0);
      check({tag, ":onehot"}, 32'(hot_err), 32'd0);
   endtask

   initial begin
      int   cyc;
      logic err;
      int   n_done;
      rst_exp[0] = 32'h0444_EF00;
      rst_exp[1] = 32'h0445_0000;
      rst_exp[2] = 32'h0446_013F;
      bus.start = 1'b0;
      bus.x = '0; bus.y = '0; bus.w = '0; bus.h = '0; bus.color = '0;

      repeat (2) @(negedge CLOCK);
      check("rst:call", {29'd0, bus.call}, 32'd0);
      check("rst:addr", {24'd0, bus.addr}, 32'd0);
      check("rst:data", {16'd0, bus.data}, 32'd0);
      check("rst:busy", {31'd0, bus.busy}, 32'd0);
      check("rst:done", {31'd0, bus.done}, 32'd0);
      check("rst:err", {31'd0, bus.err}, 32'd0);
      RESET = 1'b1;

      set_hdr(32'h0444_0D0A, 32'h0445_0014, 32'h0446_0016, 32'h044E_000A, 32'h044F_0014);
      run_fill(8'd10, 9'd20, 8'd4, 9'd3, 16'hF800, 0, 1'b0, cyc, err);
      check("t1:err", {31'd0, err}, 32'd0);
      check_seq("t1", 12, 16'hF800);

      run_fill(8'd10, 9'd20, 8'd4, 9'd3, 16'hF800, 5, 1'b1, cyc, err);
      check("t1rnd:err", {31'd0, err}, 32'd0);
      check_seq("t1rnd", 12, 16'hF800);

      set_hdr(32'h0444_EFEF, 32'h0445_013F, 32'h0446_013F, 32'h044E_00EF, 32'h044F_013F);
      run_fill(8'd239, 9'd319, 8'd1, 9'd1, 16'h07E0, 2, 1'b1, cyc, err);
      check("px1:err", {31'd0, err}, 32'd0);
      check_seq("px1", 1, 16'h07E0);

      run_fill(8'd200, 9'd0, 8'd41, 9'd3, 16'h1234, 0, 1'b0, cyc, err);
      check("rejx:err", {31'd0, err}, 32'd1);
      check("rejx:cyc", 32'(cyc), 32'd2);
      check("rejx:calls", 32'(q.size()), 32'd0);

      run_fill(8'd0, 9'd0, 8'd5, 9'd0, 16'h1234, 0, 1'b1, cyc, err);
      check("rejh:err", {31'd0, err}, 32'd1);
      check("rejh:cyc", 32'(cyc), 32'd2);
      check("rejh:calls", 32'(q.size()), 32'd0);

      run_fill(8'd3, 9'd4, 8'd0, 9'd5, 16'h1234, 0, 1'b0, cyc, err);
      check("rejw:err", {31'd0, err}, 32'd1);
      check("rejw:calls", 32'(q.size()), 32'd0);

      run_fill(8'd0, 9'd300, 8'd1, 9'd21, 16'h1234, 0, 1'b0, cyc, err);
      check("rejy:err", {31'd0, err}, 32'd1);
      check("rejy:calls", 32'(q.size()), 32'd0);

      set_hdr(32'h0444_EFC8, 32'h0445_0136, 32'h0446_013F, 32'h044E_00C8, 32'h044F_0136);
      run_fill(8'd200, 9'd310, 8'd40, 9'd10, 16'hABCD, 2, 1'b1, cyc, err);
      check("edge:err", {31'd0, err}, 32'd0);
      check_seq("edge", 400, 16'hABCD);

      set_hdr(32'h0444_EF00, 32'h0445_0000, 32'h0446_0027, 32'h044E_0000, 32'h044F_0000);
      run_fill(8'd0, 9'd0, 8'd240, 9'd40, 16'h5555, 0, 1'b0, cyc, err);
      check("big:err", {31'd0, err}, 32'd0);
      check_seq("big", 9600, 16'h5555);

      // Abort during the fifth pixel write.
      @(negedge CLOCK);
      q.delete();
      pix_seen  = 0;
      resp_max  = 1;
      bus.x = 8'd10; bus.y = 9'd20; bus.w = 8'd4; bus.h = 9'd3; bus.color = 16'hF800;
      bus.start = 1'b1;
      @(negedge CLOCK);
      bus.start = 1'b0;
      cyc = 0;
      while (pix_seen < 5 && cyc < 1000) begin
         @(negedge CLOCK);
         #1;
         cyc++;
      end
      check("abort:reached", 32'(pix_seen), 32'd5);
      RESET = 1'b0;
      #1;
      check("abort:call", {29'd0, bus.call}, 32'd0);
      check("abort:addr", {24'd0, bus.addr}, 32'd0);
      check("abort:data", {16'd0, bus.data}, 32'd0);
      check("abort:busy", {31'd0, bus.busy}, 32'd0);
      check("abort:done", {31'd0, bus.done}, 32'd0);
      n_done = 0;
      repeat (4) begin
         @(negedge CLOCK);
         if (bus.done) n_done++;
      end
      check("abort:no_done", 32'(n_done), 32'd0);
      RESET = 1'b1;

      set_hdr(32'h0444_0D0A, 32'h0445_0014, 32'h0446_0016, 32'h044E_000A, 32'h044F_0014);
      run_fill(8'd10, 9'd20, 8'd4, 9'd3, 16'h001F, 3, 1'b0, cyc, err);
      check("post:err", {31'd0, err}, 32'd0);
      check_seq("post", 12, 16'h001F);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
